alu_operand_fetch: RTL and testbench

- Multicycle operand reader that feeds the ALU; it is the input-side counterpart of the ALU result register.
- On `start` it reads source register A, then source register B or an immediate, through the single synchronous register-file read port.
- It latches both 16-bit operands and presents them to the ALU with a valid/ready handshake.
- It supports bypass from the ALU result register, so a just-computed value is used instead of a stale register-file value.

---
 rtl/risc_pkg.sv | 15 +
 rtl/operand_resolve.sv | 25 ++
 rtl/alu_operand_fetch.sv | 120 ++++++++++++
 tb/tb_alu_operand_fetch.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the operand fetch path: default widths,
// fetch FSM encoding and the hardwired-zero register address.
package risc_pkg;
  localparam int DW_DEF   = 16;
  localparam int AW_DEF   = 3;
  localparam int REG_ZERO = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    CAP_B = 3'd3,
    VALID = 3'd4
  } state_t;
endpackage

// File: rtl/operand_resolve.sv
// Picks the value for one source operand: hardwired zero, then the
// pending ALU writeback, then whatever the register file returned.
module operand_resolve
  import risc_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] rf_rdata,
  input  logic          fwd_en,
  input  logic [AW-1:0] fwd_addr,
  input  logic [DW-1:0] fwd_data,
  output logic [DW-1:0] value
);
  // Priority mux: zero register beats the bypass, bypass beats the RF.
  always_comb begin
    value = rf_rdata;
    if (R0_ZERO && (addr == AW'(REG_ZERO)))
      value = '0;
    else if (fwd_en && (fwd_addr == addr))
      value = fwd_data;
  end
endmodule

// File: rtl/alu_operand_fetch.sv
// Multicycle operand reader: fetches A then B (or immediate) through the
// single synchronous RF read port, applies bypass, and hands both operands
// to the ALU with a valid/ready handshake.
module alu_operand_fetch
  import risc_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic [DW-1:0] imm,
  input  logic          use_imm,
  output logic [AW-1:0] rf_raddr,
  output logic          rf_re,
  input  logic [DW-1:0] rf_rdata,
  input  logic          fwd_en,
  input  logic [AW-1:0] fwd_addr,
  input  logic [DW-1:0] fwd_data,
  output logic [DW-1:0] opa,
  output logic [DW-1:0] opb,
  output logic          op_valid,
  input  logic          op_ready,
  output logic          busy
);
  localparam int NOPS = 2;  // operand A = 0, operand B = 1

  state_t                   state;
  logic [AW-1:0]            rs_q, rt_q;
  logic [DW-1:0]            imm_q;
  logic                     use_imm_q;
  logic [NOPS-1:0][AW-1:0]  res_addr;
  logic [NOPS-1:0][DW-1:0]  res_val;

  assign res_addr[0] = rs_q;
  assign res_addr[1] = rt_q;

  // One resolver per operand; both watch the same RF data and bypass bus,
  // the FSM picks which result to capture in which cycle.
  generate
    for (genvar i = 0; i < NOPS; i++) begin : g_res
      operand_resolve #(.DW(DW), .AW(AW), .R0_ZERO(R0_ZERO)) u_res (
        .addr     (res_addr[i]),
        .rf_rdata (rf_rdata),
        .fwd_en   (fwd_en),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data),
        .value    (res_val[i])
      );
    end
  endgenerate

  // Fetch FSM. Read-port outputs are registered on entry to the state
  // that owns them, so RF data lands in the following state's capture.
  // op_valid rises one cycle into VALID, and the handshake only completes
  // once the ALU has actually seen it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rs_q      <= '0;
      rt_q      <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      rf_raddr  <= '0;
      rf_re     <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      op_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rs_q      <= rs_addr;
            rt_q      <= rt_addr;
            imm_q     <= imm;
            use_imm_q <= use_imm;
            rf_raddr  <= rs_addr;
            rf_re     <= 1'b1;
            busy      <= 1'b1;
            state     <= RD_A;
          end
        end
        RD_A: begin
          rf_raddr <= rt_q;
          rf_re    <= !use_imm_q;
          state    <= RD_B;
        end
        RD_B: begin
          rf_re <= 1'b0;
          opa   <= res_val[0];
          state <= CAP_B;
        end
        CAP_B: begin
          opb   <= use_imm_q ? imm_q : res_val[1];
          state <= VALID;
        end
        VALID: begin
          if (!op_valid) begin
            op_valid <= 1'b1;
          end else if (op_ready) begin
            op_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          rf_re    <= 1'b0;
          op_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed bench for alu_operand_fetch: table of fetch vectors with
// hand-computed operands, plus backpressure and mid-fetch reset sequences.
module tb_alu_operand_fetch;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] rs_addr, rt_addr;
  logic [DW-1:0] imm;
  logic          use_imm;
  logic [AW-1:0] rf_raddr;
  logic          rf_re;
  logic [DW-1:0] rf_rdata;
  logic          fwd_en;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
  logic [DW-1:0] opa, opb;
  logic          op_valid;
  logic          op_ready;
  logic          busy;

  logic [DW-1:0] rf [8];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [DW-1:0] imm;
    logic          use_imm;
    logic          fwd_en;
    logic [AW-1:0] fwd_addr;
    logic [DW-1:0] fwd_data;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
  } vec_t;

  vec_t vecs [8];

  alu_operand_fetch #(.DW(DW), .AW(AW), .R0_ZERO(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .imm      (imm),
    .use_imm  (use_imm),
    .rf_raddr (rf_raddr),
    .rf_re    (rf_re),
    .rf_rdata (rf_rdata),
    .fwd_en   (fwd_en),
    .fwd_addr (fwd_addr),
    .fwd_data (fwd_data),
    .opa      (opa),
    .opb      (opb),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Synchronous register-file model: data valid the cycle after rf_re.
  always @(posedge clk) begin
    if (rf_re) rf_rdata <= rf[rf_raddr];
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, need finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rs_addr  = v.rs;
    rt_addr  = v.rt;
    imm      = v.imm;
    use_imm  = v.use_imm;
    fwd_en   = v.fwd_en;
    fwd_addr = v.fwd_addr;
    fwd_data = v.fwd_data;
  endtask

  // Full fetch with cycle-exact checks; if done_hs, also checks the handshake.
  task automatic do_fetch(input vec_t v, input bit done_hs);
    @(negedge clk);
    drive(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rd_a raddr", 32'(rf_raddr), 32'(v.rs));
    chk("rd_a re", 32'(rf_re), 32'd1);
    chk("rd_a busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("rd_b raddr", 32'(rf_raddr), 32'(v.rt));
    chk("rd_b re", 32'(rf_re), 32'(!v.use_imm));
    @(posedge clk); #1;
    chk("cap_b re", 32'(rf_re), 32'd0);
    chk("cap_b raddr hold", 32'(rf_raddr), 32'(v.rt));
    @(posedge clk); #1;
    chk("n+3 valid low", 32'(op_valid), 32'd0);
    @(posedge clk); #1;
    chk("n+4 valid", 32'(op_valid), 32'd1);
    chk("opa", 32'(opa), 32'(v.exp_a));
    chk("opb", 32'(opb), 32'(v.exp_b));
    if (done_hs) begin
      @(posedge clk); #1;
      chk("hs busy", 32'(busy), 32'd0);
      chk("hs valid", 32'(op_valid), 32'd0);
    end
  endtask

  initial begin
    rf[0] = 16'hFFFF; rf[1] = 16'h1111; rf[2] = 16'h1234; rf[3] = 16'hAAAA;
    rf[4] = 16'h0001; rf[5] = 16'h00FF; rf[6] = 16'h6666; rf[7] = 16'h7777;
    rf_rdata = '0;
    //          rs    rt    imm       ui    fe    fa    fd         exp_a      exp_b
    vecs[0] = '{3'd2, 3'd5, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h1234, 16'h00FF};
    vecs[1] = '{3'd3, 3'd5, 16'h8001, 1'b1, 1'b0, 3'd0, 16'h0000, 16'hAAAA, 16'h8001};
    vecs[2] = '{3'd0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{3'd0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd0, 16'h5555, 16'h0000, 16'h0000};
    vecs[4] = '{3'd4, 3'd4, 16'h0000, 1'b0, 1'b1, 3'd4, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    vecs[5] = '{3'd6, 3'd7, 16'h0123, 1'b1, 1'b1, 3'd7, 16'hC0DE, 16'h6666, 16'h0123};
    vecs[6] = '{3'd1, 3'd7, 16'h0000, 1'b0, 1'b1, 3'd1, 16'h0F0F, 16'h0F0F, 16'h7777};
    vecs[7] = '{3'd7, 3'd6, 16'h0000, 1'b0, 1'b0, 3'd7, 16'hDEAD, 16'h7777, 16'h6666};

    rst_n = 1'b0; start = 1'b0; op_ready = 1'b1;
    drive(vecs[0]);
    #12;
    chk("rst opa", 32'(opa), 32'd0);
    chk("rst opb", 32'(opb), 32'd0);
    chk("rst raddr", 32'(rf_raddr), 32'd0);
    chk("rst re", 32'(rf_re), 32'd0);
    chk("rst valid", 32'(op_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) do_fetch(vecs[i], 1'b1);

    // Backpressure: operands held while op_ready low; start in VALID ignored.
    op_ready = 1'b0;
    do_fetch(vecs[0], 1'b0);
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin
        start = 1'b1;
        rs_addr = 3'd3;
        rt_addr = 3'd6;
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("bp valid", 32'(op_valid), 32'd1);
      chk("bp opa", 32'(opa), 32'h1234);
      chk("bp opb", 32'(opb), 32'h00FF);
      chk("bp busy", 32'(busy), 32'd1);
    end
    op_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release busy", 32'(busy), 32'd0);
    chk("bp release valid", 32'(op_valid), 32'd0);
    @(posedge clk); #1;
    chk("bp no queued re", 32'(rf_re), 32'd0);
    chk("bp no queued busy", 32'(busy), 32'd0);

    // Reset while in RD_B: everything clears, then a fresh fetch works.
    @(negedge clk);
    drive(vecs[6]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre-rst busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst valid", 32'(op_valid), 32'd0);
    chk("midrst opa", 32'(opa), 32'd0);
    chk("midrst opb", 32'(opb), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst re", 32'(rf_re), 32'd0);
    chk("midrst raddr", 32'(rf_raddr), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst valid", 32'(op_valid), 32'd0);
    do_fetch(vecs[4], 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
